ucsbece154b_fetch_buffer: RTL and testbench
===========================================

// Module: ucsbece154b_fetch_buffer
// PURPOSE
//  Parametrised decoupled fetch unit between I-cache and pipeline fetch stage. Issues sequential
//  fetch requests, buffers returned instructions with their PCs in a DEPTH-entry circular queue,
//  and presents the head to decode. Handles branch redirects by flushing the queue and dropping
//  stale responses. Emits a next-line prefetch hint to the prefetcher.
// PARAMETERS
//  XLEN        32           address/instruction width
//  DEPTH       4            queue entries (power of 2, >=2)
//  LINE_WORDS  4            words per cache line (power of 2); sets prefetch stride
//  RESET_PC    32'h00010000 first fetch address after reset
// PORTS
//  clk            in   1             clock, rising edge
//  reset          in   1             asynchronous, active-low reset
//  redirect_i     in   1             mispredict/jump redirect (pipeline flush)
//  redirect_pc_i  in   XLEN          new fetch address, valid with redirect_i
//  req_valid_o    out  1             fetch request to I-cache
//  req_addr_o     out  XLEN          request address (word aligned)
//  req_ready_i    in   1             cache accepts request this cycle
//  resp_valid_i   in   1             cache returns instruction (ReadyF)
//  resp_instr_i   in   XLEN          returned instruction
//  instr_valid_o  out  1             queue head valid
//  instr_o        out  XLEN          head instruction
//  pc_o           out  XLEN          head PC
//  stall_i        in   1             decode stall; head popped when instr_valid_o & !stall_i
//  pf_valid_o     out  1             one-cycle prefetch hint
//  pf_addr_o      out  XLEN          next-line address for prefetcher
//  count_o        out  clog2(DEPTH+1) entries held
// BEHAVIOUR
//  - Reset: all outputs 0, queue empty, fetch_pc=RESET_PC, FSM=IDLE; IDLE->REQ unconditionally next cycle.
//  - One outstanding request max. FSM: IDLE, REQ, WAIT, DRAIN.
//    REQ: req_valid_o=1 only if count+pending<DEPTH; on req_ready_i -> WAIT, fetch_pc+=4.
//    WAIT: on resp_valid_i push {fetch address, instr} at tail -> REQ.
//    DRAIN: on resp_valid_i discard response -> REQ.
//  - req_addr_o/req_valid_o stable until accepted (no retraction unless redirect).
//  - Redirect has highest priority: queue cleared (count=0, head=tail) same edge, fetch_pc=redirect_pc_i.
//    In WAIT, or in REQ with req_ready_i same cycle -> DRAIN; else -> REQ. resp_valid_i coincident
//    with redirect in WAIT is discarded and goes directly to REQ. Pop suppressed in redirect cycle.
//  - Push and pop same cycle: count unchanged; legal when full (pop frees slot first).
//  - Pointers log2(DEPTH) bits, wrap modulo DEPTH; full when count==DEPTH.
//  - Head outputs combinational from queue; instr_o/pc_o are 0 when empty.
//  - Latency: response to instr_valid_o = 1 cycle (registered write). Empty-queue bypass not provided.
//  - Prefetch: when a request is accepted whose word index within line == 0, pf_valid_o=1 next cycle
//    for exactly one cycle with pf_addr_o = line_base + LINE_WORDS*4. Suppressed if redirect that cycle.
//  - Addresses wrap modulo 2^XLEN; resp_valid_i in IDLE/REQ ignored.
//  - Reset asserted mid-operation: immediate return to reset state, in-flight response ignored.
// STRUCTURE
//  - Package ucsbece154b_fetch_pkg: state enum (IDLE,REQ,WAIT,DRAIN), INSTR_BYTES=4, NOP constant.
//  - Sub-module ucsbece154b_circ_queue (WIDTH=2*XLEN, DEPTH): push/pop/clear, count, head data.
//  - Top holds FSM, fetch_pc, credit check, prefetch pulse register.
// TESTING
//  1 Reset release, cache ready always, stall_i=1 -> 4 requests 0x10000..0x1000C, count_o=4, req_valid_o=0.
//  2 Redirect to 0x20000 while WAIT -> count_o=0, next response dropped, next req_addr_o=0x20000.
//  3 Full queue, stall_i=0, resp arriving -> push+pop same cycle, count_o stays 4, order preserved.
//  4 Run 10 instrs through DEPTH=4 -> pointer wrap, pc_o sequence 0x10000..0x10024, no loss/dup.
//  5 Request 0x10010 accepted -> pf_valid_o one cycle, pf_addr_o=0x10020; 0x10014 -> no pulse.
//  6 reset low during WAIT, resp_valid_i pulsed -> outputs 0, queue empty, restart at 0x10000.

Source files
------------

// File: rtl/ucsbece154b_fetch_pkg.sv
// Shared types and constants for the decoupled fetch buffer.
package ucsbece154b_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/ucsbece154b_fetch_buffer_if.sv
// Handshake bundle between the fetch buffer (master), the I-cache, decode and prefetcher.
interface ucsbece154b_fetch_buffer_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            req_valid_o;
   logic [XLEN-1:0] req_addr_o;
   logic            req_ready_i;
   logic            resp_valid_i;
   logic [XLEN-1:0] resp_instr_i;
   logic            instr_valid_o;
   logic [XLEN-1:0] instr_o;
   logic [XLEN-1:0] pc_o;
   logic            stall_i;
   logic            pf_valid_o;
   logic [XLEN-1:0] pf_addr_o;
   logic [CW-1:0]   count_o;

   modport master (
      input  redirect_i, redirect_pc_i, req_ready_i, resp_valid_i, resp_instr_i, stall_i,
      output req_valid_o, req_addr_o, instr_valid_o, instr_o, pc_o, pf_valid_o, pf_addr_o, count_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, req_ready_i, resp_valid_i, resp_instr_i, stall_i,
      input  req_valid_o, req_addr_o, instr_valid_o, instr_o, pc_o, pf_valid_o, pf_addr_o, count_o
   );

endinterface

// File: rtl/ucsbece154b_circ_queue.sv
// DEPTH-entry circular queue with synchronous clear; head data reads as zero when empty.
module ucsbece154b_circ_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             head_valid_o,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    count_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s, do_pop_s;

   // Pointer and occupancy update; a pop frees its slot before a same-cycle push.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      do_pop_s  = pop_i && (count_q != CW'(0));
      do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
      if (clear_i) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         do_push_s = 1'b0;
      end else begin
         if (do_pop_s) begin
            head_d = head_q + PW'(1);
         end else begin
            head_d = head_q;
         end
         if (do_push_s) begin
            tail_d = tail_q + PW'(1);
         end else begin
            tail_d = tail_q;
         end
         count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents never escape while the queue is empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[tail_q] <= data_i;
      end
   end

   assign head_valid_o = (count_q != CW'(0));
   assign head_o       = head_valid_o ? mem_q[head_q] : '0;
   assign count_o      = count_q;

endmodule

// File: rtl/ucsbece154b_fetch_buffer.sv
// Decoupled fetch unit: sequential I-cache requests, redirect flush, PC/instr queue, next-line hint.
module ucsbece154b_fetch_buffer
   import ucsbece154b_fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              DEPTH      = 4,
   parameter int              LINE_WORDS = 4,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0001_0000)
) (
   input logic                        clk,
   input logic                        reset,
   ucsbece154b_fetch_buffer_if.master bus
);
   localparam int              CW         = $clog2(DEPTH + 1);
   localparam int              LINE_BYTES = LINE_WORDS * INSTR_BYTES;
   localparam logic [XLEN-1:0] LINE_MASK  = XLEN'(LINE_BYTES - 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            pf_valid_q, pf_valid_d;
   logic [XLEN-1:0] pf_addr_q, pf_addr_d;

   logic            pending_s, req_valid_s, accept_s, line_start_s;
   logic            push_s, pop_s, head_valid_s;
   logic [CW-1:0]   count_s;
   logic [2*XLEN-1:0] head_s;

   // Next-state, fetch address and prefetch hint; redirect overrides every other event.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      pf_valid_d    = 1'b0;
      pf_addr_d     = '0;
      push_s        = 1'b0;
      pending_s     = (state_q == S_WAIT);
      req_valid_s   = (state_q == S_REQ) && ((int'(count_s) + int'(pending_s)) < DEPTH);
      accept_s      = req_valid_s && bus.req_ready_i;
      line_start_s  = ((fetch_pc_q & LINE_MASK) >> 2) == '0;
      pop_s         = head_valid_s && !bus.stall_i && !bus.redirect_i;
      if (bus.redirect_i) begin
         fetch_pc_d = bus.redirect_pc_i;
         case (state_q)
            S_WAIT, S_DRAIN: state_d = bus.resp_valid_i ? S_REQ : S_DRAIN;
            S_REQ:           state_d = accept_s ? S_DRAIN : S_REQ;
            S_IDLE:          state_d = S_REQ;
            default:         state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (accept_s) begin
                  state_d       = S_WAIT;
                  inflight_pc_d = fetch_pc_q;
                  fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
                  if (line_start_s) begin
                     pf_valid_d = 1'b1;
                     pf_addr_d  = (fetch_pc_q & ~LINE_MASK) + XLEN'(LINE_BYTES);
                  end else begin
                     pf_valid_d = 1'b0;
                  end
               end else begin
                  state_d = S_REQ;
               end
            end
            S_WAIT: begin
               if (bus.resp_valid_i) begin
                  push_s  = 1'b1;
                  state_d = S_REQ;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DRAIN: state_d = bus.resp_valid_i ? S_REQ : S_DRAIN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM, fetch address and registered prefetch pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         pf_valid_q    <= 1'b0;
         pf_addr_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         pf_valid_q    <= pf_valid_d;
         pf_addr_q     <= pf_addr_d;
      end
   end

   ucsbece154b_circ_queue #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (bus.redirect_i),
      .push_i       (push_s),
      .pop_i        (pop_s),
      .data_i       ({inflight_pc_q, bus.resp_instr_i}),
      .head_valid_o (head_valid_s),
      .head_o       (head_s),
      .count_o      (count_s)
   );

   assign bus.req_valid_o   = req_valid_s;
   assign bus.req_addr_o    = req_valid_s ? fetch_pc_q : '0;
   assign bus.instr_valid_o = head_valid_s;
   assign bus.pc_o          = head_s[2*XLEN-1:XLEN];
   assign bus.instr_o       = head_s[XLEN-1:0];
   assign bus.pf_valid_o    = pf_valid_q;
   assign bus.pf_addr_o     = pf_addr_q;
   assign bus.count_o       = count_s;

endmodule

// File: tb/tb_ucsbece154b_fetch_buffer.sv
// Randomised self-checking bench for the fetch buffer against a queue-based reference model.
module tb_ucsbece154b_fetch_buffer;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ucsbece154b_fetch_buffer_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

   ucsbece154b_fetch_buffer #(
      .XLEN       (32),
      .DEPTH      (DEPTH),
      .LINE_WORDS (4),
      .RESET_PC   (32'h0001_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   // Reference model: instruction queue plus "request outstanding" and "response is stale" flags.
   ent_t        mq[$];
   bit          started, outst, stale;
   logic [31:0] fpc, infl;
   bit          pf_v;
   logic [31:0] pf_a;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit exp_req_valid();
      return started && !outst && (mq.size() < DEPTH);
   endfunction

   task automatic model_reset();
      mq.delete();
      started = 1'b0;
      outst   = 1'b0;
      stale   = 1'b0;
      fpc     = 32'h0001_0000;
      infl    = 32'h0;
      pf_v    = 1'b0;
      pf_a    = 32'h0;
   endtask

   task automatic check_all();
      bit rv;
      rv = exp_req_valid();
      chk("req_valid", {31'b0, bus.req_valid_o}, {31'b0, rv});
      chk("req_addr", bus.req_addr_o, rv ? fpc : 32'h0);
      chk("instr_valid", {31'b0, bus.instr_valid_o}, {31'b0, (mq.size() > 0)});
      chk("instr", bus.instr_o, (mq.size() > 0) ? mq[0].instr : 32'h0);
      chk("pc", bus.pc_o, (mq.size() > 0) ? mq[0].pc : 32'h0);
      chk("count", {29'b0, bus.count_o}, mq.size());
      chk("pf_valid", {31'b0, bus.pf_valid_o}, {31'b0, pf_v});
      chk("pf_addr", bus.pf_addr_o, pf_a);
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                       input bit rv, input logic [31:0] ri, input bit st);
      bit acc;
      bit npf_v;
      logic [31:0] npf_a;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      bus.req_ready_i   = rdy;
      bus.resp_valid_i  = rv;
      bus.resp_instr_i  = ri;
      bus.stall_i       = st;
      acc   = exp_req_valid() && rdy;
      npf_v = 1'b0;
      npf_a = 32'h0;
      if (redir) begin
         mq.delete();
         if (outst) begin
            if (rv) begin
               outst = 1'b0;
               stale = 1'b0;
            end else begin
               stale = 1'b1;
            end
         end else if (acc) begin
            outst = 1'b1;
            stale = 1'b1;
         end
         fpc = rpc;
      end else begin
         if (mq.size() > 0 && !st) void'(mq.pop_front());
         if (outst && rv) begin
            if (!stale) mq.push_back('{infl, ri});
            outst = 1'b0;
            stale = 1'b0;
         end else if (acc) begin
            infl = fpc;
            if (((fpc / 4) % 4) == 0) begin
               npf_v = 1'b1;
               npf_a = (fpc - (fpc % 16)) + 32'd16;
            end
            fpc   = fpc + 32'd4;
            outst = 1'b1;
         end
      end
      started = 1'b1;
      pf_v    = npf_v;
      pf_a    = npf_a;
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic rand_step(input int redir_odds);
      bit          redir;
      logic [31:0] rpc;
      bit          rv;
      redir = ($urandom % redir_odds) == 0;
      rpc   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 4) * 4) : ($urandom & 32'hFFFF_FFFC);
      rv    = outst ? (($urandom % 4) != 0) : (($urandom % 8) == 0);
      step(redir, rpc, ($urandom % 3) != 0, rv, $urandom, ($urandom % 3) == 0);
   endtask

   initial begin
      int guard;
      reset             = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      bus.req_ready_i   = 1'b0;
      bus.resp_valid_i  = 1'b0;
      bus.resp_instr_i  = 32'h0;
      bus.stall_i       = 1'b1;
      model_reset();
      #12;
      check_all();
      reset = 1'b1;

      // Fill with decode stalled: four sequential fetches, then requests stop.
      repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, $urandom, 1'b1);
      chk("fill_count", {29'b0, bus.count_o}, 32'd4);
      chk("fill_req_valid", {31'b0, bus.req_valid_o}, 32'd0);
      chk("fill_head_pc", bus.pc_o, 32'h0001_0000);

      // Pop one, fetch 0x10010 (line start -> hint), redirect in WAIT, drop stale response.
      step(1'b0, 32'h0, 1'b0, 1'b0, $urandom, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, $urandom, 1'b1);
      chk("pf_pulse", {31'b0, bus.pf_valid_o}, 32'd1);
      chk("pf_line", bus.pf_addr_o, 32'h0001_0020);
      step(1'b1, 32'h0002_0000, 1'b0, 1'b0, $urandom, 1'b1);
      chk("redir_count", {29'b0, bus.count_o}, 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      chk("redir_req_valid", {31'b0, bus.req_valid_o}, 32'd1);
      chk("redir_req_addr", bus.req_addr_o, 32'h0002_0000);
      step(1'b0, 32'h0, 1'b1, 1'b0, $urandom, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
      chk("redir_head_pc", bus.pc_o, 32'h0002_0000);
      step(1'b0, 32'h0, 1'b1, 1'b0, $urandom, 1'b1);
      chk("no_pf_mid_line", {31'b0, bus.pf_valid_o}, 32'd0);

      // Streaming with decode always ready: pointer wrap, no loss or duplication.
      repeat (40) step(1'b0, 32'h0, 1'b1, 1'b1, $urandom, 1'b0);

      // Randomised traffic including redirects near the top of the address space.
      repeat (800) rand_step(30);

      // Reset mid-flight while a response is arriving.
      guard = 0;
      while (!(outst && !stale) && guard < 50) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, $urandom, 1'b0);
         guard++;
      end
      chk("reach_wait", {31'b0, (outst && !stale)}, 32'd1);
      reset            = 1'b0;
      bus.resp_valid_i = 1'b1;
      bus.resp_instr_i = 32'hCAFE_F00D;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      bus.resp_valid_i = 1'b0;
      reset            = 1'b1;
      repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, $urandom, 1'b1);
      chk("restart_head_pc", bus.pc_o, 32'h0001_0000);

      repeat (300) rand_step(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
